// File: rtl/bram_rv_ram_if.sv
// Handshake/bus bundle for bram_rv_ram: shared address, write and read channels.
interface bram_rv_ram_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    logic [ADDR_WIDTH-1:0] i_addr;
    logic [DATA_WIDTH-1:0] i_data;
    logic                  i_wr_valid;
    logic                  o_wr_ready;
    logic [DATA_WIDTH-1:0] o_data;
    logic                  o_rd_valid;
    logic                  i_rd_ready;

    modport master (
        output i_addr, i_data, i_wr_valid, i_rd_ready,
        input  o_wr_ready, o_data, o_rd_valid
    );

    modport slave (
        input  i_addr, i_data, i_wr_valid, i_rd_ready,
        output o_wr_ready, o_data, o_rd_valid
    );
endinterface

// File: rtl/bram_rv_ram.sv
// Single-port block RAM behind rv write/read handshakes, 1-cycle read latency.
// Optional BRAM_RV_WRITE_FIRST_EN: same-address read+write returns the new data.
module bram_rv_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic           i_clk,
    input  logic           i_rst,
    bram_rv_ram_if.slave   bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};
    logic                  reading;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [DATA_WIDTH-1:0] rd_next;
    logic                  wr_fire;

    assign bus.o_wr_ready = i_rst & bus.i_wr_valid;
    assign wr_fire        = bus.i_wr_valid & bus.o_wr_ready;
    assign bus.o_rd_valid = reading;
    assign bus.o_data     = rd_data;

`ifdef BRAM_RV_WRITE_FIRST_EN
    assign rd_next = wr_fire ? bus.i_data : mem[bus.i_addr];
`else
    assign rd_next = mem[bus.i_addr];
`endif

    // array kept reset-free so it maps onto block RAM
    always_ff @(posedge i_clk) begin
        if (wr_fire) begin
            mem[bus.i_addr] <= bus.i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            reading <= 1'b0;
            rd_data <= '0;
        end else begin
            reading <= bus.i_rd_ready;
            if (bus.i_rd_ready) begin
                rd_data <= rd_next;
            end
        end
    end
endmodule

// File: tb/tb_bram_rv_ram.sv
// Self-checking bench for bram_rv_ram against an array-based memory model.
module tb_bram_rv_ram;
    localparam int DW = 32;
    localparam int AW = 10;

`ifdef BRAM_RV_WRITE_FIRST_EN
    localparam bit WF = 1'b1;
`else
    localparam bit WF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;

    bram_rv_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    bram_rv_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mdl [2**AW];
    logic [DW-1:0] exp_data;
    logic          exp_valid;
    int            n_cmp  = 0;
    int            n_fail = 0;

    // Apply the memory rules to the inputs present now, then take one edge.
    task automatic cycle();
        logic          wr;
        logic [DW-1:0] old;
        wr  = rst && bus.i_wr_valid;
        old = mdl[bus.i_addr];
        if (!rst) begin
            exp_valid = 1'b0;
            exp_data  = '0;
        end else begin
            exp_valid = bus.i_rd_ready;
            if (bus.i_rd_ready)
                exp_data = (WF && wr) ? bus.i_data : old;
        end
        if (wr) mdl[bus.i_addr] = bus.i_data;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_addr     = '0;
        bus.i_data     = '0;
        bus.i_wr_valid = 1'b0;
        bus.i_rd_ready = 1'b0;
    endtask

    task automatic do_write(input int a, input logic [DW-1:0] d);
        bus.i_addr     = a[AW-1:0];
        bus.i_data     = d;
        bus.i_wr_valid = 1'b1;
        bus.i_rd_ready = 1'b0;
        cycle();
        bus.i_wr_valid = 1'b0;
    endtask

    task automatic do_read(input int a);
        bus.i_addr     = a[AW-1:0];
        bus.i_wr_valid = 1'b0;
        bus.i_rd_ready = 1'b1;
        cycle();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        cycle();
        cycle();
        rst = 1'b1;
        cycle();
        n_cmp++;
        if (dut.reading !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_reading got=%b exp=0", dut.reading);
        end
        n_cmp++;
        if (bus.o_rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_rd_valid got=%b exp=0", bus.o_rd_valid);
        end
        n_cmp++;
        if (bus.o_wr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_wr_ready got=%b exp=0", bus.o_wr_ready);
        end
    endtask

    task automatic test_write_ready();
        bus.i_addr     = 10'd21;
        bus.i_data     = 32'hAA;
        bus.i_wr_valid = 1'b1;
        #1;
        n_cmp++;
        if (bus.o_wr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_ready_high got=%b exp=1", bus.o_wr_ready);
        end
        cycle();
        bus.i_wr_valid = 1'b0;
        #1;
        n_cmp++;
        if (bus.o_wr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_ready_low got=%b exp=0", bus.o_wr_ready);
        end
        do_read(21);
        n_cmp++;
        if (dut.reading !== 1'b1 || bus.o_data !== 32'hAA) begin
            n_fail++;
            $display("FAIL read21 got=%b/%h exp=1/000000aa",
                     dut.reading, bus.o_data);
        end
    endtask

    task automatic test_back_to_back();
        do_read(22);
        n_cmp++;
        if (bus.o_data !== 32'h0 || bus.o_rd_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL read22_unwritten got=%b/%h exp=1/0",
                     bus.o_rd_valid, bus.o_data);
        end
        do_read(21);
        n_cmp++;
        if (bus.o_data !== 32'hAA || bus.o_rd_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reread21 got=%b/%h exp=1/aa",
                     bus.o_rd_valid, bus.o_data);
        end
        bus.i_rd_ready = 1'b0;
        cycle();
        n_cmp++;
        if (bus.o_rd_valid !== 1'b0 || bus.o_data !== 32'hAA) begin
            n_fail++;
            $display("FAIL read_drop_hold got=%b/%h exp=0/aa",
                     bus.o_rd_valid, bus.o_data);
        end
    endtask

    task automatic test_multi_write();
        logic [DW-1:0] want [3];
        want[0] = 32'hAA;
        want[1] = 32'hBB;
        want[2] = 32'hCC;
        for (int i = 0; i < 3; i++) do_write(21 + i, want[i]);
        for (int i = 0; i < 3; i++) begin
            do_read(21 + i);
            n_cmp++;
            if (bus.o_data !== want[i] || bus.o_rd_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL multi_read%0d got=%b/%h exp=1/%h",
                         21 + i, bus.o_rd_valid, bus.o_data, want[i]);
            end
        end
        do_write(23, 32'h2211FFEE);
        do_read(23);
        n_cmp++;
        if (bus.o_data !== 32'h2211FFEE) begin
            n_fail++;
            $display("FAIL overwrite23 got=%h exp=2211ffee", bus.o_data);
        end
        do_read(22);
        n_cmp++;
        if (bus.o_data !== 32'hBB) begin
            n_fail++;
            $display("FAIL keep22 got=%h exp=000000bb", bus.o_data);
        end
    endtask

    task automatic test_same_addr();
        logic [DW-1:0] want;
        do_write(5, 32'h11);
        bus.i_addr     = 10'd5;
        bus.i_data     = 32'h55;
        bus.i_wr_valid = 1'b1;
        bus.i_rd_ready = 1'b1;
        cycle();
        bus.i_wr_valid = 1'b0;
        want = WF ? 32'h55 : 32'h11;
        n_cmp++;
        if (bus.o_data !== want) begin
            n_fail++;
            $display("FAIL same_addr_rw got=%h exp=%h", bus.o_data, want);
        end
        do_read(5);
        n_cmp++;
        if (bus.o_data !== 32'h55) begin
            n_fail++;
            $display("FAIL same_addr_reread got=%h exp=00000055",
                     bus.o_data);
        end
    endtask

    task automatic test_reset_mid_read();
        do_read(21);
        do_read(23);
        bus.i_rd_ready = 1'b1;
        rst = 1'b0;
        cycle();
        n_cmp++;
        if (bus.o_rd_valid !== 1'b0 || bus.o_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid_read got=%b/%h exp=0/0",
                     bus.o_rd_valid, bus.o_data);
        end
        bus.i_rd_ready = 1'b0;
        bus.i_addr     = 10'd22;
        bus.i_data     = 32'hDEAD;
        bus.i_wr_valid = 1'b1;
        #1;
        n_cmp++;
        if (bus.o_wr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_ready_in_reset got=%b exp=0", bus.o_wr_ready);
        end
        cycle();
        bus.i_wr_valid = 1'b0;
        rst = 1'b1;
        cycle();
        do_read(22);
        n_cmp++;
        if (bus.o_data !== 32'hBB) begin
            n_fail++;
            $display("FAIL mem_kept_in_reset got=%h exp=000000bb",
                     bus.o_data);
        end
    endtask

    task automatic test_random();
        int a;
        for (int i = 0; i < 400; i++) begin
            a = ($urandom_range(0, 7) == 0) ? $urandom_range(1016, 1023)
                                            : $urandom_range(0, 15);
            bus.i_addr     = a[AW-1:0];
            bus.i_data     = $urandom;
            bus.i_wr_valid = $urandom_range(0, 1) == 1;
            bus.i_rd_ready = $urandom_range(0, 2) != 0;
            #1;
            n_cmp++;
            if (bus.o_wr_ready !== bus.i_wr_valid) begin
                n_fail++;
                $display("FAIL rand_wr_ready it=%0d got=%b exp=%b",
                         i, bus.o_wr_ready, bus.i_wr_valid);
            end
            cycle();
            n_cmp++;
            if (bus.o_rd_valid !== exp_valid || bus.o_data !== exp_data) begin
                n_fail++;
                $display("FAIL rand_read it=%0d got=%b/%h exp=%b/%h",
                         i, bus.o_rd_valid, bus.o_data, exp_valid, exp_data);
            end
        end
        idle_inputs();
    endtask

    initial begin
        for (int i = 0; i < 2**AW; i++) mdl[i] = '0;
        exp_data  = '0;
        exp_valid = 1'b0;
        idle_inputs();
        test_reset();
        test_write_ready();
        test_back_to_back();
        test_multi_write();
        test_same_addr();
        test_reset_mid_read();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/bram_rv_ram.md
Name: bram_rv_ram

Overview:
Single-port block RAM behind ready/valid handshakes for one write channel and one read channel, sharing one address bus.
- Writes complete in the cycle they are presented.
- Reads return registered data one clock after the request, flagged by a one-cycle valid pulse.
- Used as a generic word-addressed memory for bus masters that speak the codebase's rv protocol.

Parameters:
DATA_WIDTH, 32, word width in bits
ADDR_WIDTH, 10, address width; depth = 2**ADDR_WIDTH words

Ports:
i_clk  input  1  clock; all state changes on rising edge
i_rst  input  1  synchronous, active-low reset
i_addr  input  ADDR_WIDTH  word address for both read and write
i_data  input  DATA_WIDTH  write data
i_wr_valid  input  1  write request
o_wr_ready  output  1  write accept (combinational)
o_data  output  DATA_WIDTH  registered read data
o_rd_valid  output  1  read data valid
i_rd_ready  input  1  read request from consumer

Behaviour:
- Memory array: 2**ADDR_WIDTH x DATA_WIDTH, initialised to all zeros at configuration. Reset does not clear contents.
- Internal state register `reading` (1 bit, hierarchically visible under that name). o_rd_valid = reading.
- Reset (i_rst==0 at a rising edge):
  - reading <= 0, o_data <= 0; no write is performed.
  - o_wr_ready is forced 0 combinationally while i_rst==0.
- Write channel:
  - o_wr_ready = i_rst & i_wr_valid, combinational, same cycle.
  - Write fires on a rising edge when i_wr_valid & o_wr_ready: mem[i_addr] <= i_data.
  - Zero-latency accept; no backpressure beyond reset.
  - i_wr_valid low -> o_wr_ready low.
- Read channel:
  - On each rising edge out of reset, reading <= i_rd_ready.
  - When i_rd_ready==1 at the edge, o_data <= mem[i_addr].
  - Data and o_rd_valid are therefore available immediately after the edge that sampled the request: latency 1 clock.
  - o_rd_valid stays high for every cycle following a sampled request. Back-to-back requests give continuous valid, each with data for its own address.
  - When i_rd_ready==0 at an edge: o_data holds its previous value and reading clears.
- Simultaneous read and write at an edge, same i_addr:
  - Both are performed.
  - Default read-first: o_data gets the old contents.
- Address wrap: none. The full ADDR_WIDTH range is valid and every address is independent.
- Reset asserted mid-read: o_rd_valid drops at that edge and o_data is cleared to 0.

Optional Feature:
BRAM_RV_WRITE_FIRST_EN
- Defined: on a simultaneous read and write to the same address, o_data receives i_data (write-first bypass).
- Undefined: read-first, as in Behaviour; o_data gets the pre-write contents.
- No other behaviour differs.

Test Plan:
- After reset release, idle: reading==0, o_rd_valid==0, o_wr_ready==0.
- i_wr_valid=1, addr 21, data 0xAA -> o_wr_ready==1 in the same cycle. Drop valid after the edge -> o_wr_ready==0. Read 21 -> after one edge reading==1 and o_data==0xAA.
- Read unwritten address 22 -> o_data==0x00, reading==1. Re-read 21 -> 0xAA (back-to-back reads, valid stays high).
- Writes 21=0xAA, 22=0xBB, 23=0xCC. Reads return 0xAA, 0xBB, 0xCC. Overwrite 23=0x2211FFEE -> read 23 gives 0x2211FFEE, read 22 still gives 0xBB.
- Same-edge write 0x55 and read of addr 5 (holding 0x11):
  - Default: o_data==0x11, then a re-read gives 0x55.
  - With BRAM_RV_WRITE_FIRST_EN: o_data==0x55.
- Assert i_rst=0 during a read stream -> next edge o_rd_valid==0, o_data==0; write attempted under reset -> o_wr_ready==0 and memory unchanged.
